lock_code_writer: RTL
=====================

LOCK_CODE_WRITER -- requirements
Module: lock_code_writer

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 20000: the number of stable clk cycles required before a btn level is accepted.
REQ-002 Parameter LOCK_CYC, default 50000000: the lockout duration in clk cycles.
REQ-003 Parameter MAX_TRIES, default 3: the number of consecutive wrong old-code entries that triggers lockout.
REQ-004 Parameter INIT_CODE, default 4'b0101: the stored code value after reset.
REQ-005 clk  in  1  single system clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 sw  in  4  code switches {q,u,n,b}, MSB first, assumed quasi-static.
REQ-008 btn  in  1  raw entry key, active-high, asynchronous to clk, bouncing.
REQ-009 mode  in  1  change-code request switch; 1 = programming session active.
REQ-010 code  out  4  stored code, read by the lock checker.
REQ-011 code_upd  out  1  one-cycle pulse in the cycle that code takes its new value.
REQ-012 led_busy  out  1  active-low; 0 = programming session in progress (any state except IDLE).
REQ-013 led_err  out  1  active-low; 0 = error flag set or LOCKOUT active.

Function
REQ-014 btn shall pass through a two-flop synchronizer and then a debouncer that updates its accepted level only after DEBOUNCE_CYC consecutive equal samples; the debouncer shall be one sub-module.
REQ-015 A press event shall be a one-cycle pulse on the accepted 0->1 edge; release shall generate no event.
REQ-016 FSM states: IDLE, VERIFY, NEW, CONFIRM, LOCKOUT.
REQ-017 IDLE: when mode=1, go to VERIFY; press events in IDLE are ignored.
REQ-018 VERIFY, press with sw==code: clear tries, clear err, go to NEW.
REQ-019 VERIFY, press with sw!=code: increment tries and set err; if tries reaches MAX_TRIES, go to LOCKOUT, otherwise stay in VERIFY.
REQ-020 NEW, press: latch sw into pending, clear err, go to CONFIRM.
REQ-021 CONFIRM, press with sw==pending: write code<=pending, assert code_upd for one cycle, clear err, go to IDLE.
REQ-022 CONFIRM, press with sw!=pending: code is unchanged, set err, go to NEW.
REQ-023 mode=0 in VERIFY, NEW or CONFIRM: go to IDLE in the next cycle; pending is discarded; code and tries are unchanged.
REQ-024 If mode falls and a press event occur in the same cycle, the abort shall take priority.
REQ-025 LOCKOUT: ignore press events and mode; count LOCK_CYC cycles; then clear tries and err and go to IDLE.
REQ-026 tries shall be clog2(MAX_TRIES+1) bits wide and shall saturate at MAX_TRIES.
REQ-027 The lockout counter shall be clog2(LOCK_CYC) bits wide and shall be held at 0 outside LOCKOUT.
REQ-028 code_upd shall be registered and asserted exactly one cycle, aligned with the code change.
REQ-029 code shall change only on a successful confirm.
REQ-030 Latency from the accepted press edge to code_upd shall be 2 clk cycles (edge detect, FSM commit).

Reset
REQ-031 Asserting rst_n=0 shall immediately set: code=INIT_CODE, code_upd=0, led_busy=1, led_err=1, state=IDLE, tries=0, pending=0, counters=0, debouncer accepted level=0.
REQ-032 Reset asserted mid-session or mid-lockout shall abort the session or lockout with no partial write.
REQ-033 Reset shall be released synchronously to clk through a reset synchronizer owned by the top level.

Structure
REQ-034 The FSM state enum and INIT_CODE default shall live in the shared package lock_pkg.
REQ-035 The debouncer shall be the sub-module btn_debounce (synchronizer plus stable counter, output is the accepted level).
REQ-036 The remaining logic (FSM, registers, edge detect) shall be in lock_code_writer, about 200 lines total.

Verification (DEBOUNCE_CYC=4, LOCK_CYC=16, MAX_TRIES=3)
REQ-037 Reset, then idle 10 cycles -> code=0101, code_upd=0, led_busy=1, led_err=1.
REQ-038 mode=1; press sw=0101; press sw=1100; press sw=1100 -> single code_upd pulse, code=1100, led_busy=1 afterwards.
REQ-039 mode=1; three presses with sw=0000 -> led_err=0 after the first press, LOCKOUT after the third, presses ignored for 16 cycles, then IDLE with tries=0 and code unchanged.
REQ-040 VERIFY ok; NEW sw=0011; CONFIRM sw=0111 -> led_err=0, state NEW, code still 0101, no code_upd.
REQ-041 btn bouncing with glitches of 1-3 cycles before a stable high -> exactly one press event.
REQ-042 rst_n pulsed low while in CONFIRM -> code=0101 immediately; mode drop and press in the same cycle -> IDLE, no write.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared types and defaults for the lock code writer.
package lock_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VERIFY,
    NEW,
    CONFIRM,
    LOCKOUT
  } state_t;

  localparam logic [3:0] INIT_CODE_DEFAULT = 4'b0101;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stable-sample debouncer; level is the
// accepted button level.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 20000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // cnt counts consecutive samples that disagree with the accepted level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
      cnt   <= '0;
      level <= sync2;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lock_code_writer.sv
// Change-code session controller: verifies the old code, takes a new code
// twice and commits it, with lockout after repeated wrong old-code entries.
module lock_code_writer
  import lock_pkg::*;
#(
  parameter int         DEBOUNCE_CYC = 20000,
  parameter int         LOCK_CYC     = 50000000,
  parameter int         MAX_TRIES    = 3,
  parameter logic [3:0] INIT_CODE    = INIT_CODE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       btn,
  input  logic       mode,
  output logic [3:0] code,
  output logic       code_upd,
  output logic       led_busy,
  output logic       led_err
);

  localparam int TW  = (MAX_TRIES > 0) ? $clog2(MAX_TRIES + 1) : 1;
  localparam int LCW = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;

  logic           rst_meta;
  logic           rst_sync;
  logic           level;
  logic           level_d;
  logic           press;

  state_t         state, state_nxt;
  logic [TW-1:0]  tries, tries_nxt, tries_inc;
  logic           err, err_nxt;
  logic [3:0]     pending, pending_nxt;
  logic [3:0]     code_nxt;
  logic           upd_nxt;
  logic [LCW-1:0] lock_cnt, lock_cnt_nxt;

  // Assert asynchronously, release on a clock edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta <= 1'b0;
      rst_sync <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_sync <= rst_meta;
    end
  end

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_debounce (
    .clk  (clk),
    .rst_n(rst_sync),
    .btn  (btn),
    .level(level)
  );

  // Registered rising-edge detect gives the one-cycle press event
  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      level_d <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_d <= level;
      press   <= level & ~level_d;
    end
  end

  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      state    <= IDLE;
      tries    <= '0;
      err      <= 1'b0;
      pending  <= '0;
      code     <= INIT_CODE;
      code_upd <= 1'b0;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      tries    <= tries_nxt;
      err      <= err_nxt;
      pending  <= pending_nxt;
      code     <= code_nxt;
      code_upd <= upd_nxt;
      lock_cnt <= lock_cnt_nxt;
    end
  end

  assign tries_inc = (tries < TW'(MAX_TRIES)) ? tries + 1'b1 : tries;

  // A falling mode wins over a simultaneous press in every session state
  always_comb begin
    state_nxt    = state;
    tries_nxt    = tries;
    err_nxt      = err;
    pending_nxt  = pending;
    code_nxt     = code;
    upd_nxt      = 1'b0;
    lock_cnt_nxt = '0;
    case (state)
      IDLE: begin
        if (mode) state_nxt = VERIFY;
      end
      VERIFY, NEW, CONFIRM: begin
        if (!mode) begin
          state_nxt   = IDLE;
          pending_nxt = '0;
        end else if (press) begin
          if (state == VERIFY) begin
            if (sw == code) begin
              tries_nxt = '0;
              err_nxt   = 1'b0;
              state_nxt = NEW;
            end else begin
              tries_nxt = tries_inc;
              err_nxt   = 1'b1;
              if (tries_inc >= TW'(MAX_TRIES)) state_nxt = LOCKOUT;
            end
          end else if (state == NEW) begin
            pending_nxt = sw;
            err_nxt     = 1'b0;
            state_nxt   = CONFIRM;
          end else if (sw == pending) begin
            code_nxt  = pending;
            upd_nxt   = 1'b1;
            err_nxt   = 1'b0;
            state_nxt = IDLE;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = NEW;
          end
        end
      end
      LOCKOUT: begin
        if (lock_cnt == LCW'(LOCK_CYC - 1)) begin
          tries_nxt = '0;
          err_nxt   = 1'b0;
          state_nxt = IDLE;
        end else begin
          lock_cnt_nxt = lock_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign led_busy = (state == IDLE);
  assign led_err  = ~(err | (state == LOCKOUT));

endmodule
